// File: rtl/cmp_result_monitor.sv
// Debounces comparator eq/gt/lt flags into a settled relation state with change/error pulses.
// Optional per-code sample histogram enabled by defining CMP_MON_HISTOGRAM_EN.
module cmp_result_monitor #(
    parameter int STABLE_CNT = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             eq,
    input  logic             gt,
    input  logic             lt,
    output logic [1:0]       state,
    output logic             state_valid,
    output logic             change_pulse,
    output logic             err_pulse,
    output logic [CNT_W-1:0] change_count
`ifdef CMP_MON_HISTOGRAM_EN
    ,
    output logic [CNT_W-1:0] eq_count,
    output logic [CNT_W-1:0] gt_count,
    output logic [CNT_W-1:0] lt_count
`endif
);

    localparam logic [1:0] ST_UNK  = 2'b00;
    localparam logic [1:0] ST_EQ   = 2'b01;
    localparam logic [1:0] ST_GT   = 2'b10;
    localparam logic [1:0] ST_LT   = 2'b11;
    localparam logic [3:0] RUN_MAX = 4'(STABLE_CNT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [1:0]       r_cand;
    logic [3:0]       r_run;
    logic [1:0]       r_state;
    logic             r_chg;
    logic             r_err;
    logic [CNT_W-1:0] r_chg_cnt;

    logic [1:0]       w_code;
    logic             w_onehot;
    logic             w_good;
    logic             w_bad;
    logic [1:0]       w_cand_nxt;
    logic [3:0]       w_run_nxt;
    logic             w_commit;

    always_comb begin
        w_code   = ST_UNK;
        w_onehot = 1'b0;
        case ({eq, gt, lt})
            3'b100: begin w_code = ST_EQ; w_onehot = 1'b1; end
            3'b010: begin w_code = ST_GT; w_onehot = 1'b1; end
            3'b001: begin w_code = ST_LT; w_onehot = 1'b1; end
            default: begin w_code = ST_UNK; w_onehot = 1'b0; end
        endcase
    end

    assign w_good = in_valid & w_onehot;
    assign w_bad  = in_valid & ~w_onehot;

    // Run length saturates so a long steady stream never wraps back into a false commit.
    always_comb begin
        w_cand_nxt = r_cand;
        w_run_nxt  = r_run;
        if (w_bad) begin
            w_cand_nxt = ST_UNK;
            w_run_nxt  = 4'd0;
        end else if (w_good) begin
            if (w_code == r_cand) begin
                w_run_nxt = (r_run >= RUN_MAX) ? RUN_MAX : r_run + 4'd1;
            end else begin
                w_cand_nxt = w_code;
                w_run_nxt  = 4'd1;
            end
        end
    end

    assign w_commit = w_good && (w_run_nxt == RUN_MAX) && (w_cand_nxt != r_state);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand    <= ST_UNK;
            r_run     <= 4'd0;
            r_state   <= ST_UNK;
            r_chg     <= 1'b0;
            r_err     <= 1'b0;
            r_chg_cnt <= '0;
        end else begin
            r_cand <= w_cand_nxt;
            r_run  <= w_run_nxt;
            r_chg  <= w_commit;
            r_err  <= w_bad;
            if (w_commit) begin
                r_state   <= w_cand_nxt;
                r_chg_cnt <= sat_inc(r_chg_cnt);
            end
        end
    end

    assign state        = r_state;
    assign state_valid  = (r_state != ST_UNK);
    assign change_pulse = r_chg;
    assign err_pulse    = r_err;
    assign change_count = r_chg_cnt;

`ifdef CMP_MON_HISTOGRAM_EN
    // Raw sample histogram: counts every valid one-hot sample, independent of debouncing.
    logic [CNT_W-1:0] r_eq_cnt;
    logic [CNT_W-1:0] r_gt_cnt;
    logic [CNT_W-1:0] r_lt_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_eq_cnt <= '0;
            r_gt_cnt <= '0;
            r_lt_cnt <= '0;
        end else if (w_good) begin
            if (w_code == ST_EQ) r_eq_cnt <= sat_inc(r_eq_cnt);
            if (w_code == ST_GT) r_gt_cnt <= sat_inc(r_gt_cnt);
            if (w_code == ST_LT) r_lt_cnt <= sat_inc(r_lt_cnt);
        end
    end

    assign eq_count = r_eq_cnt;
    assign gt_count = r_gt_cnt;
    assign lt_count = r_lt_cnt;
`endif

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Directed bench for cmp_result_monitor (STABLE_CNT=3, CNT_W=8, default build).
module tb_cmp_result_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       eq;
    logic       gt;
    logic       lt;
    logic [1:0] state;
    logic       state_valid;
    logic       change_pulse;
    logic       err_pulse;
    logic [7:0] change_count;

    int n_chk = 0;
    int n_bad = 0;
    int n_pulse;

    cmp_result_monitor #(.STABLE_CNT(3), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .eq           (eq),
        .gt           (gt),
        .lt           (lt),
        .state        (state),
        .state_valid  (state_valid),
        .change_pulse (change_pulse),
        .err_pulse    (err_pulse),
        .change_count (change_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Present one sample for one cycle; outputs are checked 1 time unit after the edge.
    task automatic send(input logic v, input logic [2:0] f);
        in_valid = v;
        {eq, gt, lt} = f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        send(1'b0, 3'b000);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        {eq, gt, lt} = 3'b000;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_sv", 32'(state_valid), 32'd0);
        chk("rst_cp", 32'(change_pulse), 32'd0);
        chk("rst_ep", 32'(err_pulse), 32'd0);
        chk("rst_cnt", 32'(change_count), 32'd0);
        rst = 1'b0;

        // First lock to GT
        send(1'b1, 3'b010); chk("gt1_state", 32'(state), 32'd0);
        send(1'b1, 3'b010); chk("gt2_state", 32'(state), 32'd0);
        chk("gt2_cp", 32'(change_pulse), 32'd0);
        send(1'b1, 3'b010); chk("gt3_state", 32'(state), 32'd2);
        chk("gt3_cp", 32'(change_pulse), 32'd1);
        chk("gt3_cnt", 32'(change_count), 32'd1);
        chk("gt3_sv", 32'(state_valid), 32'd1);
        idle();             chk("gt_idle_cp", 32'(change_pulse), 32'd0);
        chk("gt_idle_state", 32'(state), 32'd2);

        // LT, LT, EQ, LT, LT, LT
        send(1'b1, 3'b001); chk("l1_state", 32'(state), 32'd2);
        send(1'b1, 3'b001); chk("l2_state", 32'(state), 32'd2);
        send(1'b1, 3'b100); chk("e_state", 32'(state), 32'd2);
        send(1'b1, 3'b001); chk("l3_state", 32'(state), 32'd2);
        send(1'b1, 3'b001); chk("l4_state", 32'(state), 32'd2);
        chk("l4_cp", 32'(change_pulse), 32'd0);
        send(1'b1, 3'b001); chk("l5_state", 32'(state), 32'd3);
        chk("l5_cp", 32'(change_pulse), 32'd1);
        chk("l5_cnt", 32'(change_count), 32'd2);

        // Malformed flags
        send(1'b1, 3'b011); chk("err1_ep", 32'(err_pulse), 32'd1);
        chk("err1_state", 32'(state), 32'd3);
        chk("err1_cp", 32'(change_pulse), 32'd0);
        send(1'b1, 3'b000); chk("err2_ep", 32'(err_pulse), 32'd1);
        chk("err2_state", 32'(state), 32'd3);
        send(1'b1, 3'b100); chk("eq1_ep", 32'(err_pulse), 32'd0);
        chk("eq1_state", 32'(state), 32'd3);
        send(1'b1, 3'b100); chk("eq2_state", 32'(state), 32'd3);
        send(1'b1, 3'b100); chk("eq3_state", 32'(state), 32'd1);
        chk("eq3_cnt", 32'(change_count), 32'd3);
        send(1'b1, 3'b100); chk("eq4_cp", 32'(change_pulse), 32'd0);
        chk("eq4_cnt", 32'(change_count), 32'd3);

        // Gaps inside a GT run
        send(1'b1, 3'b010);
        idle();
        send(1'b1, 3'b010); chk("gap2_state", 32'(state), 32'd1);
        idle();
        idle();             chk("gap_idle_cp", 32'(change_pulse), 32'd0);
        send(1'b1, 3'b010); chk("gap3_state", 32'(state), 32'd2);
        chk("gap3_cp", 32'(change_pulse), 32'd1);
        chk("gap3_cnt", 32'(change_count), 32'd4);

        // Reset mid-run; sample in the reset cycle is ignored
        send(1'b1, 3'b001);
        send(1'b1, 3'b001);
        rst = 1'b1;
        send(1'b1, 3'b001);
        rst = 1'b0;
        chk("mrst_state", 32'(state), 32'd0);
        chk("mrst_sv", 32'(state_valid), 32'd0);
        chk("mrst_cp", 32'(change_pulse), 32'd0);
        chk("mrst_cnt", 32'(change_count), 32'd0);
        send(1'b1, 3'b001); chk("r1_state", 32'(state), 32'd0);
        send(1'b1, 3'b001); chk("r2_state", 32'(state), 32'd0);
        send(1'b1, 3'b001); chk("r3_state", 32'(state), 32'd3);
        chk("r3_cnt", 32'(change_count), 32'd1);

        // 300 alternating runs starting from LT: each commits
        n_pulse = 0;
        for (int r = 0; r < 300; r++) begin
            for (int k = 0; k < 3; k++) begin
                send(1'b1, (r % 2 == 0) ? 3'b010 : 3'b001);
                if (change_pulse) n_pulse++;
            end
        end
        chk("sat_pulses", 32'(n_pulse), 32'd300);
        chk("sat_cp_last", 32'(change_pulse), 32'd1);
        chk("sat_cnt", 32'(change_count), 32'd255);
        chk("sat_state", 32'(state), 32'd3);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
